host_switch_ctrl: RTL and testbench
===================================

// Module: host_switch_ctrl
// PURPOSE
//  Sequences the A/B host changeover that drives the io switch select. It decides
//  the host from heartbeat health (pulse detectors), command swaps and forced
//  selection, and freezes the switched io around each changeover so no glitch
//  reaches the field. It also rate-limits swaps and flags loss of both CPUs.
// PARAMETERS
//  GUARD_CYC    16    cycles io_freeze is held before switch toggles (>=1)
//  SETTLE_CYC   16    cycles io_freeze is held after switch toggles (>=1)
//  HOLDOFF_CYC  1024  post-swap hold-off; auto/command swaps ignored (>=1)
//  RST_CYC      256   reset pulse width for old host (SWI_AUTO_RESET_EN only)
//  CNT_W        16    internal timer width; must hold max of the above
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  alive_a    in   1  CPU A heartbeat valid (pulse detector A io)
//  alive_b    in   1  CPU B heartbeat valid (pulse detector B io)
//  com_swi    in   1  single-cycle swap request from command decoder
//  force_swi  in   1  level: force host to force_sel
//  force_sel  in   1  forced host, 0=A 1=B
//  switch     out  1  io select, 0=A host, 1=B host
//  io_freeze  out  1  hold switched outputs at last value
//  busy       out  1  changeover or hold-off in progress
//  both_dead  out  1  host and standby both lack heartbeat
//  swi_count  out  8  switchover count, saturates at 255
//  reset_A    out  1  reset request to CPU A, active high
//  reset_B    out  1  reset request to CPU B, active high
// BEHAVIOUR
//  Reset: state HOST_A, switch=0, io_freeze=0, busy=0, both_dead=0,
//   swi_count=0, reset_A=reset_B=0, timer=0. rst_n low at any time, including
//   mid-sequence, aborts the sequence at once.
//  States: HOST_A, HOST_B, GUARD, SETTLE, HOLD.
//  Triggers are sampled only in HOST_x, priority force > auto > command:
//   force: force_swi=1 and force_sel!=switch; swap even if standby dead.
//   auto: host not alive and standby alive.
//   command: com_swi=1 and standby alive. A com_swi seen outside HOST_x, or
//    with the standby dead, is dropped (not queued).
//  Trigger at edge T: enter GUARD at T+1 with io_freeze=1 and busy=1.
//   switch toggles at T+1+GUARD_CYC and swi_count increments (saturating);
//   then SETTLE for SETTLE_CYC cycles with io_freeze=1.
//  Leaving SETTLE: io_freeze=0; HOLD for HOLDOFF_CYC cycles, busy=1.
//   In HOLD, auto and com triggers are ignored; force is evaluated on entry to
//   HOST_x. Then enter HOST_A or HOST_B per switch, busy=0.
//  both_dead: registered; 1 in HOST_x while alive_a=alive_b=0; no swap occurs;
//   clears the cycle after either alive returns; held at 0 outside HOST_x.
//  force_swi held with force_sel==switch: no action. force_sel toggled while
//   held: one swap per HOLD window.
// CONFIGURATION
//  SWI_AUTO_RESET_EN defined: on the cycle switch toggles, the old host's reset
//   (reset_A if leaving A, else reset_B) goes 1 for RST_CYC cycles, using its own
//   counter independent of the GUARD/SETTLE/HOLD timer. A new swap restarts it.
//  Not defined: reset_A=reset_B=0 constantly and the counter is not built.
// TESTING
//  alive_a=1,alive_b=1, com_swi pulse at T -> io_freeze 1 at T+1; switch=1 at
//   T+17; freeze 0 at T+33; busy 0 at T+1057; swi_count=1.
//  alive_a drops, alive_b=1 -> auto swap to B; drop alive_b during HOLD -> no
//   swap until HOLD ends, then swap back to A; swi_count=2.
//  alive_a=alive_b=0 -> both_dead=1 next cycle, switch unchanged, no freeze.
//  force_swi=1,force_sel=1,alive_b=0 -> swap to B anyway. com_swi with standby
//   dead -> ignored.
//  rst_n low during GUARD -> switch=0, io_freeze=0, busy=0 immediately, async.
//  SWI_AUTO_RESET_EN: A->B swap -> reset_A high exactly 256 cycles from toggle,
//   reset_B stays 0. Without the macro, both stay 0.
//  Swap 256 times -> swi_count stays at 255.

Source files
------------

// File: rtl/host_switch_ctrl.sv
// A/B host changeover sequencer: picks the io host from heartbeat, command and force inputs, freezing io around each switch.
// Optional macro SWI_AUTO_RESET_EN adds a timed reset pulse to the host being switched away from.
module host_switch_ctrl #(
  parameter int GUARD_CYC   = 16,
  parameter int SETTLE_CYC  = 16,
  parameter int HOLDOFF_CYC = 1024,
  parameter int RST_CYC     = 256,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alive_a,
  input  logic       alive_b,
  input  logic       com_swi,
  input  logic       force_swi,
  input  logic       force_sel,
  output logic       switch,
  output logic       io_freeze,
  output logic       busy,
  output logic       both_dead,
  output logic [7:0] swi_count,
  output logic       reset_A,
  output logic       reset_B
);

  localparam logic [2:0] S_HOST_A = 3'd0;
  localparam logic [2:0] S_HOST_B = 3'd1;
  localparam logic [2:0] S_GUARD  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLDOFF_CYC - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_switch;
  logic             r_freeze;
  logic             r_busy;
  logic             r_both_dead;
  logic [7:0]       r_count;

  logic w_in_host;
  logic w_host_alive;
  logic w_stby_alive;
  logic w_force_trig;
  logic w_auto_trig;
  logic w_com_trig;
  logic w_trigger;
  logic w_timer_done;
  logic w_toggle;

  assign w_in_host    = (r_state == S_HOST_A) || (r_state == S_HOST_B);
  assign w_host_alive = r_switch ? alive_b : alive_a;
  assign w_stby_alive = r_switch ? alive_a : alive_b;
  assign w_force_trig = force_swi && (force_sel != r_switch);
  assign w_auto_trig  = !w_host_alive && w_stby_alive;
  assign w_com_trig   = com_swi && w_stby_alive;
  // Every trigger source launches the same sequence, so priority only matters for which one "wins" conceptually.
  assign w_trigger    = w_in_host && (w_force_trig || w_auto_trig || w_com_trig);
  assign w_timer_done = (r_timer == '0);
  assign w_toggle     = (r_state == S_GUARD) && w_timer_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HOST_A;
      r_timer     <= '0;
      r_switch    <= 1'b0;
      r_freeze    <= 1'b0;
      r_busy      <= 1'b0;
      r_both_dead <= 1'b0;
      r_count     <= 8'd0;
    end else begin
      r_both_dead <= w_in_host && !w_trigger && !alive_a && !alive_b;
      case (r_state)
        S_HOST_A, S_HOST_B: begin
          if (w_trigger) begin
            r_state  <= S_GUARD;
            r_timer  <= GUARD_LOAD;
            r_freeze <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_GUARD: begin
          if (w_timer_done) begin
            r_switch <= ~r_switch;
            if (r_count != 8'hFF) r_count <= r_count + 8'd1;
            r_state  <= S_SETTLE;
            r_timer  <= SETTLE_LOAD;
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (w_timer_done) begin
            r_freeze <= 1'b0;
            r_state  <= S_HOLD;
            r_timer  <= HOLD_LOAD;
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (w_timer_done) begin
            r_busy  <= 1'b0;
            r_state <= r_switch ? S_HOST_B : S_HOST_A;
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        default: begin
          r_state  <= S_HOST_A;
          r_timer  <= '0;
          r_freeze <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign switch    = r_switch;
  assign io_freeze = r_freeze;
  assign busy      = r_busy;
  assign both_dead = r_both_dead;
  assign swi_count = r_count;

`ifdef SWI_AUTO_RESET_EN
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYC - 1);

  logic [CNT_W-1:0] r_rst_cnt;
  logic             r_reset_a;
  logic             r_reset_b;

  // Pulse the host being abandoned; a later swap retargets and restarts the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_cnt <= '0;
      r_reset_a <= 1'b0;
      r_reset_b <= 1'b0;
    end else if (w_toggle) begin
      r_rst_cnt <= RST_LOAD;
      r_reset_a <= ~r_switch;
      r_reset_b <= r_switch;
    end else if (r_reset_a || r_reset_b) begin
      if (r_rst_cnt == '0) begin
        r_reset_a <= 1'b0;
        r_reset_b <= 1'b0;
      end else begin
        r_rst_cnt <= r_rst_cnt - CNT_W'(1);
      end
    end
  end

  assign reset_A = r_reset_a;
  assign reset_B = r_reset_b;
`else
  assign reset_A = 1'b0;
  assign reset_B = 1'b0;
`endif

endmodule

// File: tb/tb_host_switch_ctrl.sv
// Directed bench for host_switch_ctrl with a timed expectation scoreboard checked on the falling edge.
module tb_host_switch_ctrl;

  localparam int G = 16;
  localparam int S = 16;
  localparam int H = 32;
  localparam int R = 256;
  localparam int D = 1 + G + S + H;

`ifdef SWI_AUTO_RESET_EN
  localparam logic [7:0] AR = 8'd1;
`else
  localparam logic [7:0] AR = 8'd0;
`endif

  localparam int SW = 0, FRZ = 1, BSY = 2, BD = 3, CNT = 4, RA = 5, RB = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       alive_a = 1'b1;
  logic       alive_b = 1'b1;
  logic       com_swi = 1'b0;
  logic       force_swi = 1'b0;
  logic       force_sel = 1'b0;
  logic       switch;
  logic       io_freeze;
  logic       busy;
  logic       both_dead;
  logic [7:0] swi_count;
  logic       reset_A;
  logic       reset_B;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         at;
    int         sig;
    logic [7:0] exp;
    string      tag;
  } exp_t;
  exp_t sb[$];

  host_switch_ctrl #(
    .GUARD_CYC(G), .SETTLE_CYC(S), .HOLDOFF_CYC(H), .RST_CYC(R), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .alive_a(alive_a), .alive_b(alive_b),
    .com_swi(com_swi), .force_swi(force_swi), .force_sel(force_sel),
    .switch(switch), .io_freeze(io_freeze), .busy(busy), .both_dead(both_dead),
    .swi_count(swi_count), .reset_A(reset_A), .reset_B(reset_B)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [7:0] got, logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [7:0] obs(int sig);
    case (sig)
      SW:      return {7'd0, switch};
      FRZ:     return {7'd0, io_freeze};
      BSY:     return {7'd0, busy};
      BD:      return {7'd0, both_dead};
      CNT:     return swi_count;
      RA:      return {7'd0, reset_A};
      default: return {7'd0, reset_B};
    endcase
  endfunction

  task automatic push(int at, int sig, logic [7:0] v, string tag);
    exp_t e;
    e.at = at; e.sig = sig; e.exp = v; e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, obs(sb[i].sig), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(int t);
    while (cyc < t) tick(1);
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb.size() > 0 && n < 5000) begin
      tick(1);
      n++;
    end
    if (sb.size() > 0) begin
      chk("scoreboard_drain", 8'(sb.size()), 8'd0);
      sb.delete();
    end
  endtask

  initial begin
    int c;
    int h;
    // Reset state
    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_switch", {7'd0, switch}, 8'd0);
    chk("rst_freeze", {7'd0, io_freeze}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_both_dead", {7'd0, both_dead}, 8'd0);
    chk("rst_count", swi_count, 8'd0);
    chk("rst_reset_A", {7'd0, reset_A}, 8'd0);
    rst_n = 1'b1;
    tick(2);

    // Command swap A->B; timing of freeze/switch/busy and the reset pulse
    c = cyc;
    com_swi = 1'b1;
    push(c + 1, FRZ, 1, "cmd_freeze_on");
    push(c + 1, BSY, 1, "cmd_busy_on");
    push(c + G, SW, 0, "cmd_switch_pre");
    push(c + 1 + G, SW, 1, "cmd_switch_toggle");
    push(c + 1 + G, CNT, 1, "cmd_count");
    push(c + G + S, FRZ, 1, "cmd_freeze_last");
    push(c + 1 + G + S, FRZ, 0, "cmd_freeze_off");
    push(c + G + S + H, BSY, 1, "cmd_busy_last");
    push(c + D, BSY, 0, "cmd_busy_off");
    push(c + 1 + G, RA, AR, "cmd_resetA_on");
    push(c + G + R, RA, AR, "cmd_resetA_last");
    push(c + 1 + G + R, RA, 0, "cmd_resetA_off");
    push(c + 1 + G, RB, 0, "cmd_resetB_idle");
    push(c + G + R, RB, 0, "cmd_resetB_idle2");
    tick(1);
    com_swi = 1'b0;
    tick_to(c + 40);
    com_swi = 1'b1;
    push(c + D + 3, SW, 1, "hold_cmd_dropped_sw");
    push(c + D + 3, FRZ, 0, "hold_cmd_dropped_frz");
    tick(1);
    com_swi = 1'b0;
    wait_sb();

    // Auto swap B->A, then host A dies during HOLD: swap back only after HOLD
    c = cyc;
    alive_b = 1'b0;
    push(c + 1, FRZ, 1, "auto_freeze_on");
    push(c + 1 + G, SW, 0, "auto_switch_A");
    push(c + 1 + G, CNT, 2, "auto_count");
    push(c + 1 + G, RB, AR, "auto_resetB_on");
    push(c + 1 + G, RA, 0, "auto_resetA_off");
    tick_to(c + 1 + G + S + 5);
    alive_a = 1'b0;
    alive_b = 1'b1;
    h = c + D;
    push(h, BSY, 0, "auto_hold_end");
    push(h, SW, 0, "auto_hold_no_swap");
    push(h + 1, FRZ, 1, "auto_back_freeze");
    push(h + G, SW, 0, "auto_back_pre");
    push(h + 1 + G, SW, 1, "auto_back_switch");
    push(h + 1 + G, CNT, 3, "auto_back_count");
    push(h + D, BSY, 0, "auto_back_done");
    wait_sb();

    // Both dead on host B: flag, no swap; command with dead standby dropped
    c = cyc;
    alive_b = 1'b0;
    push(c + 1, BD, 1, "dead_flag");
    push(c + 1, FRZ, 0, "dead_no_freeze");
    push(c + 1, BSY, 0, "dead_no_busy");
    push(c + 1 + G, SW, 1, "dead_switch_kept");
    tick_to(c + 3);
    com_swi = 1'b1;
    push(c + 4, FRZ, 0, "dead_cmd_drop");
    push(c + 5, FRZ, 0, "dead_cmd_drop2");
    tick(1);
    com_swi = 1'b0;
    tick_to(c + 5);
    alive_b = 1'b1;
    push(c + 5, BD, 1, "dead_flag_held");
    push(c + 6, BD, 0, "dead_flag_clear");
    wait_sb();

    // Force to A even though A is dead; held force matching switch does nothing
    c = cyc;
    force_swi = 1'b1;
    force_sel = 1'b0;
    push(c + 1, FRZ, 1, "force_freeze_on");
    push(c + 1 + G, SW, 0, "force_switch_A");
    push(c + 1 + G, CNT, 4, "force_count");
    tick_to(c + 1 + G + 5);
    alive_a = 1'b1;
    push(c + D, BSY, 0, "force_done");
    push(c + D + 3, FRZ, 0, "force_held_idle");
    push(c + D + 3, SW, 0, "force_held_sw");
    wait_sb();
    force_swi = 1'b0;

    // Command with standby B dead is dropped
    c = cyc;
    alive_b = 1'b0;
    com_swi = 1'b1;
    push(c + 1, FRZ, 0, "stby_dead_frz");
    push(c + 2, FRZ, 0, "stby_dead_frz2");
    push(c + 2, SW, 0, "stby_dead_sw");
    push(c + 2, CNT, 4, "stby_dead_cnt");
    push(c + 2, BD, 0, "stby_dead_bd");
    tick(1);
    com_swi = 1'b0;
    wait_sb();
    alive_b = 1'b1;
    tick(1);

    // Swap to B, then assert rst_n mid-GUARD of the next swap
    c = cyc;
    com_swi = 1'b1;
    push(c + 1 + G, SW, 1, "pre_rst_sw");
    push(c + 1 + G, CNT, 5, "pre_rst_cnt");
    push(c + D, BSY, 0, "pre_rst_done");
    tick(1);
    com_swi = 1'b0;
    wait_sb();
    c = cyc;
    com_swi = 1'b1;
    tick(1);
    com_swi = 1'b0;
    tick_to(c + 5);
    chk("guard_freeze", {7'd0, io_freeze}, 8'd1);
    chk("guard_busy", {7'd0, busy}, 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_switch", {7'd0, switch}, 8'd0);
    chk("async_freeze", {7'd0, io_freeze}, 8'd0);
    chk("async_busy", {7'd0, busy}, 8'd0);
    chk("async_count", swi_count, 8'd0);
    chk("async_reset_A", {7'd0, reset_A}, 8'd0);
    chk("async_reset_B", {7'd0, reset_B}, 8'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Saturation of the swap counter over 256 swaps
    for (int i = 0; i < 256; i++) begin
      c = cyc;
      com_swi = 1'b1;
      push(c + 1 + G, CNT, (i + 1 > 255) ? 8'd255 : 8'(i + 1), "sat_count");
      tick(1);
      com_swi = 1'b0;
      tick_to(c + D);
    end
    wait_sb();
    chk("sat_final", swi_count, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
